// File: rtl/spi_target.sv
// SPI mode-0 target: synchronizes the controller pins into FastClk, shifts RX/TX bytes MSB first, with a one-byte TX holding register.
// Pin edges are acted on in the third FastClk cycle after the change; RXData/RXValid appear one cycle after the 8th rising SPI_Clk.
// TXReady = holding register empty; when no byte is ready at a byte boundary, FILL is sent and TXUnderrun sticks for the frame.
module spi_target #(
  parameter logic [7:0] FILL  = 8'hFF,
  parameter int         CNT_W = 10
) (
  input  logic             FastClk,
  input  logic             Reset,
  input  logic             SPI_Clk,
  input  logic             SPI_Cs,
  input  logic             SPI_Mosi,
  output logic             SPI_Miso,
  input  logic [7:0]       TXData,
  input  logic             TXValid,
  output logic             TXReady,
  output logic [7:0]       RXData,
  output logic             RXValid,
  output logic [CNT_W-1:0] ByteCount,
  output logic             TXUnderrun,
  output logic             Busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nxt;
  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       cs_prev, sclk_prev;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic       enter, leave, shift_in, shift_out, tx_load;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;
  logic [7:0] hold;
  logic       hold_full;
  logic       miso_q;
  logic [7:0] tx_next;
  logic       bypass, fill_used, hold_load;

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      cs_sync   <= 2'b11;
      cs_prev   <= 1'b1;
      sclk_sync <= 2'b00;
      sclk_prev <= 1'b0;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], SPI_Cs};
      cs_prev   <= cs_sync[1];
      sclk_sync <= {sclk_sync[0], SPI_Clk};
      sclk_prev <= sclk_sync[1];
      mosi_sync <= {mosi_sync[0], SPI_Mosi};
    end
  end

  // A chip-select edge masks any SPI_Clk edge seen in the same cycle.
  assign cs_fall   = cs_prev & ~cs_sync[1];
  assign cs_rise   = ~cs_prev & cs_sync[1];
  assign sclk_rise = ~(cs_fall | cs_rise) & ~sclk_prev & sclk_sync[1];
  assign sclk_fall = ~(cs_fall | cs_rise) & sclk_prev & ~sclk_sync[1];

  always_ff @(posedge FastClk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    leave     = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          enter     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          leave     = 1'b1;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_load   = enter | (shift_out & (bit_cnt == 3'd0));
  assign tx_next   = hold_full ? hold : (TXValid ? TXData : FILL);
  assign bypass    = tx_load & ~hold_full & TXValid;
  assign fill_used = tx_load & ~hold_full & ~TXValid;
  assign hold_load = TXValid & ~hold_full & ~bypass;

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      bit_cnt    <= 3'd0;
      rx_sr      <= 7'd0;
      tx_sr      <= 7'd0;
      hold       <= 8'd0;
      hold_full  <= 1'b0;
      miso_q     <= 1'b1;
      RXData     <= 8'd0;
      RXValid    <= 1'b0;
      ByteCount  <= '0;
      TXUnderrun <= 1'b0;
    end else begin
      RXValid <= 1'b0;
      if (hold_load) begin
        hold      <= TXData;
        hold_full <= 1'b1;
      end else if (tx_load && hold_full) begin
        hold_full <= 1'b0;
      end
      if (enter) begin
        bit_cnt    <= 3'd0;
        ByteCount  <= '0;
        TXUnderrun <= 1'b0;
      end
      if (leave) begin
        bit_cnt <= 3'd0;
        miso_q  <= 1'b1;
      end
      // The load that accompanies frame entry may itself set the underrun flag.
      if (tx_load) begin
        tx_sr  <= tx_next[6:0];
        miso_q <= tx_next[7];
        if (fill_used) TXUnderrun <= 1'b1;
      end else if (shift_out) begin
        tx_sr  <= {tx_sr[5:0], 1'b0};
        miso_q <= tx_sr[6];
      end
      if (shift_in) begin
        rx_sr   <= {rx_sr[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          RXData  <= {rx_sr, mosi_sync[1]};
          RXValid <= 1'b1;
          if (ByteCount != {CNT_W{1'b1}}) ByteCount <= ByteCount + 1'b1;
        end
      end
    end
  end

  assign SPI_Miso = miso_q;
  assign TXReady  = ~hold_full;
  assign Busy     = (state == SHIFT);

endmodule
